// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcodes, FSM state codes, instruction classes and per-class step count
package control_unit_pkg;
    localparam int OPC_W    = 5;
    localparam int MAX_STEP = 7;

    localparam logic [OPC_W-1:0] OP_LD   = 5'h00, OP_LDI  = 5'h01, OP_ST   = 5'h02, OP_ADD  = 5'h03;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'h04, OP_AND  = 5'h05, OP_OR   = 5'h06, OP_ROR  = 5'h07;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'h08, OP_SHR  = 5'h09, OP_SHRA = 5'h0A, OP_SHL  = 5'h0B;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'h0C, OP_ANDI = 5'h0D, OP_ORI  = 5'h0E, OP_MUL  = 5'h0F;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'h10, OP_NEG  = 5'h11, OP_NOT  = 5'h12, OP_BR   = 5'h13;
    localparam logic [OPC_W-1:0] OP_JR   = 5'h14, OP_JAL  = 5'h15, OP_IN   = 5'h16, OP_OUT  = 5'h17;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'h18, OP_MFLO = 5'h19, OP_NOP  = 5'h1A, OP_HALT = 5'h1B;

    // T-states occupy 8..15 so bit 3 means "running" and bits 2:0 are the step index.
    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_INIT = 4'd1, S_HALT = 4'd2,
        S_T0 = 4'd8, S_T1 = 4'd9, S_T2 = 4'd10, S_T3 = 4'd11,
        S_T4 = 4'd12, S_T5 = 4'd13, S_T6 = 4'd14, S_T7 = 4'd15
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_IMM, C_MD, C_UN, C_LD, C_LDI, C_ST, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } class_e;

    function automatic logic [2:0] last_step(input class_e c);
        case (c)
            C_R, C_IMM, C_LDI: return 3'd5;
            C_MD, C_BR:        return 3'd6;
            C_UN, C_JAL:       return 3'd4;
            C_LD, C_ST:        return 3'(MAX_STEP);
            default:           return 3'd3;
        endcase
    endfunction
endpackage

// File: rtl/control_unit_opcode_class_decoder.sv
// rtl/control_unit_opcode_class_decoder.sv - maps a 5-bit opcode onto its execute-sequence class
module opcode_class_decoder
    import control_unit_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output class_e           op_class
);
    always_comb begin
        op_class = C_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  op_class = C_R;
            OP_ADDI, OP_ANDI, OP_ORI:         op_class = C_IMM;
            OP_MUL, OP_DIV:                   op_class = C_MD;
            OP_NEG, OP_NOT:                   op_class = C_UN;
            OP_LD:                            op_class = C_LD;
            OP_LDI:                           op_class = C_LDI;
            OP_ST:                            op_class = C_ST;
            OP_BR:                            op_class = C_BR;
            OP_JR:                            op_class = C_JR;
            OP_JAL:                           op_class = C_JAL;
            OP_IN:                            op_class = C_IN;
            OP_OUT:                           op_class = C_OUT;
            OP_MFHI:                          op_class = C_MFHI;
            OP_MFLO:                          op_class = C_MFLO;
            OP_HALT:                          op_class = C_HALT;
            default:                          op_class = C_NOP;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore FSM sequencing fetch/execute strobes; CU_STEP_EN adds single-step gating
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir_data,
    input  logic        con_out,
    input  logic        stop,
`ifdef CU_STEP_EN
    input  logic        step,
`endif
    output logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out,
    output logic mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, hi_enable, lo_enable, r8_enable,
    output logic read, ram_write, pc_increment, con_enable, outport_enable, pc_init_enable,
    output logic gra, grb, grc, r_in, r_out, ba_out,
    output logic run
);
    state_e     state;
    class_e     op_class;
    logic       step_go;
    logic [2:0] step_idx;
    logic       unused_ir;

    assign step_idx  = state[2:0];
    assign run       = state[3];
    assign unused_ir = ^ir_data[31-OPC_W:0];

`ifdef CU_STEP_EN
    assign step_go = step;
`else
    assign step_go = 1'b1;
`endif

    opcode_class_decoder u_decoder (
        .opcode   (ir_data[31:32-OPC_W]),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET: state <= S_INIT;
                S_INIT:  state <= S_T0;
                S_HALT:  state <= S_HALT;
                S_T0:    if (step_go) state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                default: begin
                    if (state == S_T3 && op_class == C_HALT)
                        state <= S_HALT;
                    else if (step_idx >= last_step(op_class))
                        state <= stop ? S_HALT : S_T0;
                    else
                        state <= state_e'(state + 4'd1);
                end
            endcase
        end
    end

    always_comb begin
        {pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out} = '0;
        {mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, hi_enable, lo_enable, r8_enable} = '0;
        {read, ram_write, pc_increment, con_enable, outport_enable, pc_init_enable} = '0;
        {gra, grb, grc, r_in, r_out, ba_out} = '0;
        case (state)
            S_INIT: pc_init_enable = 1'b1;
            S_T0: if (step_go) begin pc_out = 1'b1; pc_increment = 1'b1; mar_enable = 1'b1; z_enable = 1'b1; end
            S_T1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (op_class)
                    C_R, C_IMM: case (state)
                        S_T3: begin grb = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                        S_T4: begin
                            z_enable = 1'b1;
                            if (op_class == C_IMM) c_sign_extended_out = 1'b1;
                            else begin grc = 1'b1; r_out = 1'b1; end
                        end
                        S_T5: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                        default: ;
                    endcase
                    C_MD: case (state)
                        S_T3: begin gra = 1'b1; r_out = 1'b1; y_enable = 1'b1; end
                        S_T4: begin grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
                        S_T5: begin zlo_out = 1'b1; lo_enable = 1'b1; end
                        S_T6: begin zhi_out = 1'b1; hi_enable = 1'b1; end
                        default: ;
                    endcase
                    C_UN: case (state)
                        S_T3: begin grb = 1'b1; r_out = 1'b1; z_enable = 1'b1; end
                        S_T4: begin zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                        default: ;
                    endcase
                    // ld, ldi and st share the effective-address computation in T3/T4.
                    C_LD, C_LDI, C_ST: case (state)
                        S_T3: begin grb = 1'b1; r_out = 1'b1; ba_out = 1'b1; y_enable = 1'b1; end
                        S_T4: begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
                        S_T5: begin
                            zlo_out = 1'b1;
                            if (op_class == C_LDI) begin gra = 1'b1; r_in = 1'b1; end
                            else mar_enable = 1'b1;
                        end
                        S_T6: begin
                            mdr_enable = 1'b1;
                            if (op_class == C_ST) begin gra = 1'b1; r_out = 1'b1; end
                            else read = 1'b1;
                        end
                        S_T7: begin
                            if (op_class == C_ST) ram_write = 1'b1;
                            else begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                        end
                        default: ;
                    endcase
                    C_BR: case (state)
                        S_T3: begin gra = 1'b1; r_out = 1'b1; con_enable = 1'b1; end
                        S_T4: begin pc_out = 1'b1; y_enable = 1'b1; end
                        S_T5: begin c_sign_extended_out = 1'b1; z_enable = 1'b1; end
                        S_T6: begin zlo_out = 1'b1; pc_enable = con_out; end
                        default: ;
                    endcase
                    C_JR:  if (state == S_T3) begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
                    C_JAL: case (state)
                        S_T3: begin pc_out = 1'b1; r8_enable = 1'b1; end
                        S_T4: begin gra = 1'b1; r_out = 1'b1; pc_enable = 1'b1; end
                        default: ;
                    endcase
                    C_IN:   if (state == S_T3) begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_OUT:  if (state == S_T3) begin gra = 1'b1; r_out = 1'b1; outport_enable = 1'b1; end
                    C_MFHI: if (state == S_T3) begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_MFLO: if (state == S_T3) begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against a sequence-table model
module tb_control_unit;
    typedef logic [29:0] vec_t;

    localparam vec_t PC_OUT = 30'd1 << 0,  ZLO = 30'd1 << 1,  ZHI = 30'd1 << 2,  HI_OUT = 30'd1 << 3;
    localparam vec_t LO_OUT = 30'd1 << 4,  MDR_OUT = 30'd1 << 5, INPORT = 30'd1 << 6, CSE = 30'd1 << 7;
    localparam vec_t MAR = 30'd1 << 8,  MDR_EN = 30'd1 << 9,  IR_EN = 30'd1 << 10, Y_EN = 30'd1 << 11;
    localparam vec_t Z_EN = 30'd1 << 12, PC_EN = 30'd1 << 13, HI_EN = 30'd1 << 14, LO_EN = 30'd1 << 15;
    localparam vec_t R8_EN = 30'd1 << 16, READ = 30'd1 << 17, RAM_WR = 30'd1 << 18, PC_INC = 30'd1 << 19;
    localparam vec_t CON_EN = 30'd1 << 20, OUTPORT = 30'd1 << 21, PC_INIT = 30'd1 << 22, GRA = 30'd1 << 23;
    localparam vec_t GRB = 30'd1 << 24, GRC = 30'd1 << 25, R_IN = 30'd1 << 26, R_OUT = 30'd1 << 27;
    localparam vec_t BA = 30'd1 << 28, RUN = 30'd1 << 29;
    localparam vec_t F0 = PC_OUT | PC_INC | MAR | Z_EN | RUN;

    logic clk = 1'b0;
    logic clr, con_out, stop;
    logic [31:0] ir_data;
    logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out;
    logic mar_enable, mdr_enable, ir_enable, y_enable, z_enable, pc_enable, hi_enable, lo_enable, r8_enable;
    logic read, ram_write, pc_increment, con_enable, outport_enable, pc_init_enable;
    logic gra, grb, grc, r_in, r_out, ba_out, run;

    int checks = 0;
    int errors = 0;
    vec_t exp_q[$];
    bit   halt_exp;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .ir_data(ir_data), .con_out(con_out), .stop(stop),
        .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out), .lo_out(lo_out),
        .mdr_out(mdr_out), .inport_out(inport_out), .c_sign_extended_out(c_sign_extended_out),
        .mar_enable(mar_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable), .y_enable(y_enable),
        .z_enable(z_enable), .pc_enable(pc_enable), .hi_enable(hi_enable), .lo_enable(lo_enable),
        .r8_enable(r8_enable), .read(read), .ram_write(ram_write), .pc_increment(pc_increment),
        .con_enable(con_enable), .outport_enable(outport_enable), .pc_init_enable(pc_init_enable),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .run(run)
    );

    function automatic vec_t obs();
        return {run, ba_out, r_out, r_in, grc, grb, gra, pc_init_enable, outport_enable, con_enable,
                pc_increment, ram_write, read, r8_enable, lo_enable, hi_enable, pc_enable, z_enable,
                y_enable, ir_enable, mdr_enable, mar_enable, c_sign_extended_out, inport_out, mdr_out,
                lo_out, hi_out, zhi_out, zlo_out, pc_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle strobe sets for one instruction, T0 onward, straight from the sequence tables.
    task automatic build(input logic [4:0] op, input logic con);
        exp_q.delete();
        halt_exp = 1'b0;
        exp_q.push_back(F0);
        exp_q.push_back(ZLO | PC_EN | READ | MDR_EN | RUN);
        exp_q.push_back(MDR_OUT | IR_EN | RUN);
        if (op >= 5'h03 && op <= 5'h0B) begin
            exp_q.push_back(GRB | R_OUT | Y_EN | RUN);
            exp_q.push_back(GRC | R_OUT | Z_EN | RUN);
            exp_q.push_back(ZLO | GRA | R_IN | RUN);
        end else if (op >= 5'h0C && op <= 5'h0E) begin
            exp_q.push_back(GRB | R_OUT | Y_EN | RUN);
            exp_q.push_back(CSE | Z_EN | RUN);
            exp_q.push_back(ZLO | GRA | R_IN | RUN);
        end else if (op == 5'h0F || op == 5'h10) begin
            exp_q.push_back(GRA | R_OUT | Y_EN | RUN);
            exp_q.push_back(GRB | R_OUT | Z_EN | RUN);
            exp_q.push_back(ZLO | LO_EN | RUN);
            exp_q.push_back(ZHI | HI_EN | RUN);
        end else if (op == 5'h11 || op == 5'h12) begin
            exp_q.push_back(GRB | R_OUT | Z_EN | RUN);
            exp_q.push_back(ZLO | GRA | R_IN | RUN);
        end else if (op <= 5'h02) begin
            exp_q.push_back(GRB | R_OUT | BA | Y_EN | RUN);
            exp_q.push_back(CSE | Z_EN | RUN);
            if (op == 5'h01) exp_q.push_back(ZLO | GRA | R_IN | RUN);
            else exp_q.push_back(ZLO | MAR | RUN);
            if (op == 5'h00) begin
                exp_q.push_back(READ | MDR_EN | RUN);
                exp_q.push_back(MDR_OUT | GRA | R_IN | RUN);
            end else if (op == 5'h02) begin
                exp_q.push_back(GRA | R_OUT | MDR_EN | RUN);
                exp_q.push_back(RAM_WR | RUN);
            end
        end else begin
            case (op)
                5'h13: begin
                    exp_q.push_back(GRA | R_OUT | CON_EN | RUN);
                    exp_q.push_back(PC_OUT | Y_EN | RUN);
                    exp_q.push_back(CSE | Z_EN | RUN);
                    exp_q.push_back(ZLO | (con ? PC_EN : 30'd0) | RUN);
                end
                5'h14: exp_q.push_back(GRA | R_OUT | PC_EN | RUN);
                5'h15: begin
                    exp_q.push_back(PC_OUT | R8_EN | RUN);
                    exp_q.push_back(GRA | R_OUT | PC_EN | RUN);
                end
                5'h16: exp_q.push_back(INPORT | GRA | R_IN | RUN);
                5'h17: exp_q.push_back(GRA | R_OUT | OUTPORT | RUN);
                5'h18: exp_q.push_back(HI_OUT | GRA | R_IN | RUN);
                5'h19: exp_q.push_back(LO_OUT | GRA | R_IN | RUN);
                5'h1B: begin exp_q.push_back(RUN); halt_exp = 1'b1; end
                default: exp_q.push_back(RUN);
            endcase
        end
    endtask

    task automatic do_reset(input string name);
        clr = 1'b1; stop = 1'b0; con_out = 1'b0;
        tick(); tick();
        clr = 1'b0;
        checks++;
        if (obs() !== 30'd0) begin errors++; $display("FAIL %s_reset_state: got %h expected %h", name, obs(), 30'd0); end
        tick();
        checks++;
        if (obs() !== PC_INIT) begin errors++; $display("FAIL %s_init: got %h expected %h", name, obs(), PC_INIT); end
        tick();
        checks++;
        if (obs() !== F0) begin errors++; $display("FAIL %s_t0_entry: got %h expected %h", name, obs(), F0); end
    endtask

    // Drives one instruction from T0; abort_at >= 0 asserts clr after checking that step.
    task automatic run_instr(input string name, input logic [4:0] op, input logic [26:0] rest,
                             input logic con, input bit stop_last, input int abort_at);
        build(op, con);
        ir_data = {op, rest};
        for (int i = 0; i < exp_q.size(); i++) begin
            con_out = con;
            stop = stop_last && (i == exp_q.size() - 1);
            checks++;
            if (obs() !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_T%0d op=%h: got %h expected %h", name, i, op, obs(), exp_q[i]);
            end
            if (i == abort_at) begin
                do_reset({name, "_abort"});
                return;
            end
            tick();
        end
        stop = 1'b0;
        if (halt_exp || stop_last) begin
            checks++;
            if (obs() !== 30'd0) begin errors++; $display("FAIL %s_halted: got %h expected %h", name, obs(), 30'd0); end
        end else begin
            checks++;
            if (obs() !== F0) begin errors++; $display("FAIL %s_back_to_t0: got %h expected %h", name, obs(), F0); end
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_add();
        run_instr("add", 5'h03, 27'h0918000, 1'b0, 1'b0, -1);
    endtask

    task automatic test_store();
        int writes;
        run_instr("st", 5'h02, 27'($urandom), 1'b0, 1'b0, -1);
        writes = 0;
        foreach (exp_q[i]) if (exp_q[i] & RAM_WR) writes++;
        checks++;
        if (writes !== 1) begin errors++; $display("FAIL st_model_writes: got %0d expected 1", writes); end
        run_instr("st_abort", 5'h02, 27'($urandom), 1'b0, 1'b0, 6);
    endtask

    task automatic test_branch_jal();
        run_instr("br_c0", 5'h13, 27'($urandom), 1'b0, 1'b0, -1);
        run_instr("br_c1", 5'h13, 27'($urandom), 1'b1, 1'b0, -1);
        run_instr("jal", 5'h15, 27'($urandom), 1'b0, 1'b0, -1);
        run_instr("mul", 5'h0F, 27'($urandom), 1'b0, 1'b0, -1);
    endtask

    task automatic test_halt();
        int pc_en_seen;
        pc_en_seen = 0;
        run_instr("halt", 5'h1B, 27'($urandom), 1'b0, 1'b0, -1);
        for (int k = 0; k < 10; k++) begin
            con_out = 1'($urandom);
            if (pc_enable === 1'b1) pc_en_seen++;
            checks++;
            if (obs() !== 30'd0) begin errors++; $display("FAIL halt_hold_%0d: got %h expected %h", k, obs(), 30'd0); end
            tick();
        end
        checks++;
        if (pc_en_seen !== 0) begin errors++; $display("FAIL halt_pc_enable: got %0d expected 0", pc_en_seen); end
        do_reset("halt_exit");
    endtask

    task automatic test_stop();
        run_instr("stop_add", 5'h03, 27'($urandom), 1'b0, 1'b1, -1);
        tick();
        checks++;
        if (obs() !== 30'd0) begin errors++; $display("FAIL stop_held: got %h expected %h", obs(), 30'd0); end
        do_reset("stop_exit");
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'h1B) op = 5'h1A;
            run_instr("rand", op, 27'($urandom), 1'($urandom), 1'b0, -1);
        end
    endtask

    initial begin
        clr = 1'b1; stop = 1'b0; con_out = 1'b0; ir_data = 32'd0;
        test_reset();
        test_add();
        test_store();
        test_branch_jal();
        test_halt();
        test_stop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
